adder_seq_nb: RTL and testbench

ADDER_SEQ_NB -- requirements
Module: adder_seq_nb

---
 rtl/adder_seq_nb.sv | 119 +++++++++++
 tb/tb_adder_seq_nb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_nb.sv
// Slice-serial adder: WIDTH/SLICE cycles per sum, LSB slice first; latency N edges accept->DONE.
// No backpressure: START is ignored while BUSY, results hold until the next completion.
module adder_seq_nb #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] IN0,
  input  logic [WIDTH-1:0] IN1,
  input  logic             CARRY_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY_OUT,
  output logic             OVERFLOW
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_CPLT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE:0]   ssum;
  logic [WIDTH-1:0] acc_shift;
  logic             last;
  logic             accept;

  // Operands shift right each cycle, so the active slice is always the low SLICE bits.
  assign ssum      = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + {{SLICE{1'b0}}, c_q};
  assign acc_shift = (acc_q >> SLICE) | (WIDTH'(ssum[SLICE-1:0]) << (WIDTH - SLICE));
  assign last      = (cnt_q == CW'(N - 1));
  assign accept    = START && ((state_q == S_IDLE) || (state_q == S_CPLT));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_ADD: begin
        a_d   = a_q >> SLICE;
        b_d   = b_q >> SLICE;
        c_d   = ssum[SLICE];
        acc_d = acc_shift;
        if (last) begin
          sum_d   = acc_shift;
          cout_d  = ssum[SLICE];
          // carry into the MSB is a^b^s at that bit
          ovf_d   = a_q[SLICE-1] ^ b_q[SLICE-1] ^ ssum[SLICE-1] ^ ssum[SLICE];
          state_d = S_CPLT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (accept) begin
          a_d     = IN0;
          b_d     = IN1;
          c_d     = CARRY_IN;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_ADD;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign BUSY      = (state_q == S_ADD);
  assign DONE      = (state_q == S_CPLT);
  assign SUM       = sum_q;
  assign CARRY_OUT = cout_q;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_adder_seq_nb.sv
// Bench for adder_seq_nb: a 16/4 instance and an 8/8 instance checked every cycle
// against a transaction-level model, plus hand-computed literal checks.
module tb_adder_seq_nb;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, START, CARRY_IN;
  logic [15:0] IN0, IN1;
  logic        BUSY, DONE, CARRY_OUT, OVERFLOW;
  logic [15:0] SUM;

  logic        st8, ci8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, co8, ov8;
  logic [7:0]  sum8;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  adder_seq_nb #(.WIDTH(16), .SLICE(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .IN0(IN0), .IN1(IN1), .CARRY_IN(CARRY_IN),
    .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .CARRY_OUT(CARRY_OUT), .OVERFLOW(OVERFLOW)
  );

  adder_seq_nb #(.WIDTH(8), .SLICE(8)) dut8 (
    .CLK(CLK), .RST(RST), .START(st8), .IN0(a8), .IN1(b8), .CARRY_IN(ci8),
    .BUSY(busy8), .DONE(done8), .SUM(sum8), .CARRY_OUT(co8), .OVERFLOW(ov8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          m_rem  [2];
  bit          m_busy [2];
  bit          m_done [2];
  logic [15:0] m_sum  [2];
  bit          m_co   [2];
  bit          m_ov   [2];
  logic [15:0] p_sum  [2];
  bit          p_co   [2];
  bit          p_ov   [2];

  function automatic void golden(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input bit ci, output logic [15:0] s, output bit co, output bit ov);
    longint full;
    longint mask;
    full = longint'(a) + longint'(b) + longint'(ci);
    mask = (longint'(1) << w) - 1;
    s    = 16'(full & mask);
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
  endfunction

  task automatic model_step(input int i, input int w, input int n, input bit start,
                            input logic [15:0] a, input logic [15:0] b, input bit ci);
    logic [15:0] s;
    bit co, ov;
    if (m_busy[i]) begin
      m_rem[i]--;
      if (m_rem[i] == 0) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b1;
        m_sum[i]  = p_sum[i];
        m_co[i]   = p_co[i];
        m_ov[i]   = p_ov[i];
      end
    end else begin
      m_done[i] = 1'b0;
      if (start) begin
        golden(w, a, b, ci, s, co, ov);
        m_busy[i] = 1'b1;
        m_rem[i]  = n;
        p_sum[i]  = s;
        p_co[i]   = co;
        p_ov[i]   = ov;
      end
    end
  endtask

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        m_rem[i] = 0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
        m_sum[i] = '0; m_co[i] = 1'b0; m_ov[i] = 1'b0;
      end
    end else begin
      model_step(0, 16, 4, START, IN0, IN1, CARRY_IN);
      model_step(1, 8, 1, st8, {8'h00, a8}, {8'h00, b8}, ci8);
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("cyc16{busy,done,co,ov,sum}", 32'({BUSY, DONE, CARRY_OUT, OVERFLOW, SUM}),
            32'({m_busy[0], m_done[0], m_co[0], m_ov[0], m_sum[0]}));
      check("cyc8{busy,done,co,ov,sum}", 32'({busy8, done8, co8, ov8, sum8}),
            32'({m_busy[1], m_done[1], m_co[1], m_ov[1], m_sum[1][7:0]}));
    end
  end

  // ---------------- stimulus ----------------
  // Called #1 after an edge with the 16-bit DUT idle or completing.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit ci,
                        output int lat, output int nbusy);
    IN0 = a; IN1 = b; CARRY_IN = ci; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; IN0 = '0; IN1 = '0; CARRY_IN = 1'b0;
    lat = 0; nbusy = 0;
    while (lat < 20) begin
      if (BUSY) nbusy++;
      @(posedge CLK); lat++; #1;
      if (DONE) break;
    end
  endtask

  logic [15:0] bt_a [4] = '{16'h0F0F, 16'hAAAA, 16'h4000, 16'h0001};
  logic [15:0] bt_b [4] = '{16'hF0F1, 16'h5555, 16'h4000, 16'h0002};
  bit          bt_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [15:0] bt_s [4] = '{16'h0000, 16'h0000, 16'h8000, 16'h0004};
  bit          bt_co[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  bit          bt_ov[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int lat, nb, k, cyc, last_done, nd;
    RST = 1'b1; START = 1'b0; IN0 = '0; IN1 = '0; CARRY_IN = 1'b0;
    st8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b1;
    repeat (2) @(posedge CLK);
    #1; chk_en = 1'b1;
    check("rst_busy", 32'(BUSY), 0);
    check("rst_done", 32'(DONE), 0);
    check("rst_sum", 32'(SUM), 0);
    check("rst_co_ov", 32'({CARRY_OUT, OVERFLOW}), 0);
    check("rst_busy8_start_overridden", 32'(busy8), 0);

    // 8/8 instance: accepted on the first edge after reset release, DONE one edge later
    RST = 1'b0;
    @(posedge CLK); #1;
    check("w8_accept_busy", 32'(busy8), 1);
    st8 = 1'b0;
    @(posedge CLK); #1;
    check("w8_done", 32'(done8), 1);
    check("w8_sum", 32'(sum8), 32'h01);
    check("w8_co_ov", 32'({co8, ov8}), 32'b10);
    @(posedge CLK); #1;
    check("w8_done_one_cycle", 32'(done8), 0);

    run_op(16'hFFFF, 16'h0001, 1'b0, lat, nb);
    check("ffff_latency", lat, 4);
    check("ffff_busy_cycles", nb, 4);
    check("ffff_sum", 32'(SUM), 32'h0000);
    check("ffff_co_ov", 32'({CARRY_OUT, OVERFLOW}), 32'b10);

    run_op(16'h7FFF, 16'h0001, 1'b0, lat, nb);
    check("7fff_sum", 32'(SUM), 32'h8000);
    check("7fff_co_ov", 32'({CARRY_OUT, OVERFLOW}), 32'b01);

    run_op(16'h8000, 16'h8000, 1'b0, lat, nb);
    check("8000_sum", 32'(SUM), 32'h0000);
    check("8000_co_ov", 32'({CARRY_OUT, OVERFLOW}), 32'b11);

    run_op(16'h1234, 16'h4321, 1'b1, lat, nb);
    check("1234_sum_operands_zeroed", 32'(SUM), 32'h5556);
    check("1234_co_ov", 32'({CARRY_OUT, OVERFLOW}), 32'b00);

    // back-to-back with START held high; first acceptance is from CPLT
    IN0 = bt_a[0]; IN1 = bt_b[0]; CARRY_IN = bt_c[0]; START = 1'b1;
    k = 0; cyc = 0; last_done = 0;
    while (k < 4 && cyc < 100) begin
      @(posedge CLK); cyc++; #1;
      if (DONE) begin
        check($sformatf("b2b%0d_sum", k), 32'(SUM), 32'(bt_s[k]));
        check($sformatf("b2b%0d_co_ov", k), 32'({CARRY_OUT, OVERFLOW}), 32'({bt_co[k], bt_ov[k]}));
        if (k > 0) check($sformatf("b2b%0d_gap", k), cyc - last_done, 5);
        last_done = cyc;
        k++;
        if (k < 4) begin
          IN0 = bt_a[k]; IN1 = bt_b[k]; CARRY_IN = bt_c[k];
        end else begin
          START = 1'b0;
        end
      end
    end
    check("b2b_results", k, 4);
    START = 1'b0;
    @(posedge CLK); #1;

    // reset two cycles after acceptance aborts the operation
    IN0 = 16'h1111; IN1 = 16'h2222; CARRY_IN = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("abort_outputs", 32'({BUSY, DONE, CARRY_OUT, OVERFLOW, SUM}), 0);
    nd = 0;
    repeat (8) begin
      @(posedge CLK); #1;
      if (DONE) nd++;
    end
    check("abort_no_done", nd, 0);

    run_op(16'h00FF, 16'h0F01, 1'b0, lat, nb);
    check("post_rst_latency", lat, 4);
    check("post_rst_sum", 32'(SUM), 32'h1000);
    check("post_rst_co_ov", 32'({CARRY_OUT, OVERFLOW}), 32'b00);

    repeat (3) @(posedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
